// File: rtl/register_file_sb.sv
// Register file with N combinational read ports, one write port, write-to-read
// bypass, optional hardwired-zero r0, a per-register pending scoreboard and a
// sequential bulk-clear engine that zeroes one register per cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready=1, writes and reserves accepted, clearReq starts a clear
// ST_CLEAR | ready=0, regs[idx]/pending[idx] zeroed each cycle, inputs dropped
module register_file_sb #(
  parameter int DataWidth    = 16,
  parameter int NumRegs      = 8,
  parameter int NumReadPorts = 2,
  parameter int ZeroReg      = 1,
  parameter int Bypass       = 1,
  localparam int IndexWidth  = $clog2(NumRegs)
) (
  input  logic                                     clk,
  input  logic                                     rstN,
  input  logic                                     writeEn,
  input  logic [IndexWidth-1:0]                    writeAddr,
  input  logic [DataWidth-1:0]                     writeData,
  input  logic                                     reserveEn,
  input  logic [IndexWidth-1:0]                    reserveAddr,
  input  logic [NumReadPorts-1:0][IndexWidth-1:0]  readAddr,
  output logic [NumReadPorts-1:0][DataWidth-1:0]   readData,
  output logic [NumReadPorts-1:0]                  readBusy,
  input  logic                                     clearReq,
  output logic                                     ready
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  // idx carries one extra bit so the end compare works when NumRegs is a power of two
  localparam logic [IndexWidth:0] LastIdx = (IndexWidth+1)'(NumRegs - 1);

  state_t                state_q, state_d;
  logic [IndexWidth:0]   idx_q, idx_d;
  logic [DataWidth-1:0]  regs_q [NumRegs];
  logic [DataWidth-1:0]  regs_d [NumRegs];
  logic [NumRegs-1:0]    pending_q, pending_d;
  logic                  wr_ok;
  logic                  rsv_ok;

  // Guards against indices beyond NumRegs when NumRegs is not a power of two
  function automatic logic in_range(input logic [IndexWidth-1:0] a);
    return int'(a) < NumRegs;
  endfunction

  assign ready = (state_q == ST_IDLE);

  // Qualified write/reserve strobes: only while idle, never to a hardwired r0
  always_comb begin
    wr_ok  = writeEn && ready && in_range(writeAddr)
             && !(ZeroReg != 0 && writeAddr == '0);
    rsv_ok = reserveEn && ready && in_range(reserveAddr)
             && !(ZeroReg != 0 && reserveAddr == '0);
  end

  // Next-state logic for the clear FSM, register array and scoreboard
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    regs_d    = regs_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_ok) begin
          regs_d[writeAddr]    = writeData;
          pending_d[writeAddr] = 1'b0;
        end
        // a reserve issued alongside a write to the same index leaves it pending
        if (rsv_ok) begin
          pending_d[reserveAddr] = 1'b1;
        end
        if (clearReq) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        regs_d[idx_q[IndexWidth-1:0]]    = '0;
        pending_d[idx_q[IndexWidth-1:0]] = 1'b0;
        idx_d                            = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, index, register array and scoreboard flops
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      regs_q    <= '{default: '0};
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  // Combinational read ports with same-cycle write bypass
  always_comb begin
    for (int i = 0; i < NumReadPorts; i++) begin
      readData[i] = '0;
      readBusy[i] = 1'b0;
      if (!(ZeroReg != 0 && readAddr[i] == '0) && in_range(readAddr[i])) begin
        if (Bypass != 0 && writeEn && ready && writeAddr == readAddr[i]) begin
          readData[i] = writeData;
          // a same-cycle reserve of this index keeps showing the old pending bit
          if (rsv_ok && reserveAddr == readAddr[i]) begin
            readBusy[i] = pending_q[readAddr[i]];
          end
        end else begin
          readData[i] = regs_q[readAddr[i]];
          readBusy[i] = pending_q[readAddr[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: a bypassing and a non-bypassing instance
// share all inputs; a vector table covers reads, bypass, scoreboard and r0, and
// hand-written sequences cover the bulk clear and a reset during clear.
module tb_register_file_sb;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int NP = 2;
  localparam int IW = 3;

  logic                   clk = 1'b0;
  logic                   rstN;
  logic                   writeEn;
  logic [IW-1:0]          writeAddr;
  logic [DW-1:0]          writeData;
  logic                   reserveEn;
  logic [IW-1:0]          reserveAddr;
  logic [NP-1:0][IW-1:0]  readAddr;
  logic [NP-1:0][DW-1:0]  readData;
  logic [NP-1:0]          readBusy;
  logic                   clearReq;
  logic                   ready;
  logic [NP-1:0][DW-1:0]  nb_readData;
  logic [NP-1:0]          nb_readBusy;
  logic                   nb_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  register_file_sb #(.DataWidth(DW), .NumRegs(NR), .NumReadPorts(NP),
                     .ZeroReg(1), .Bypass(1)) u_dut (
    .clk(clk), .rstN(rstN), .writeEn(writeEn), .writeAddr(writeAddr),
    .writeData(writeData), .reserveEn(reserveEn), .reserveAddr(reserveAddr),
    .readAddr(readAddr), .readData(readData), .readBusy(readBusy),
    .clearReq(clearReq), .ready(ready)
  );

  register_file_sb #(.DataWidth(DW), .NumRegs(NR), .NumReadPorts(NP),
                     .ZeroReg(1), .Bypass(0)) u_nobyp (
    .clk(clk), .rstN(rstN), .writeEn(writeEn), .writeAddr(writeAddr),
    .writeData(writeData), .reserveEn(reserveEn), .reserveAddr(reserveAddr),
    .readAddr(readAddr), .readData(nb_readData), .readBusy(nb_readBusy),
    .clearReq(clearReq), .ready(nb_ready)
  );

  typedef struct {
    logic          we;
    logic [IW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [IW-1:0] rsa;
    logic [IW-1:0] a0;
    logic [IW-1:0] a1;
    logic [DW-1:0] d0;
    logic          b0;
    logic [DW-1:0] d1;
    logic          b1;
    logic [DW-1:0] nd0;
    logic          nb0;
    logic [DW-1:0] nd1;
    logic          nb1;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(input int we, input int wa, input int wd,
                              input int re, input int rsa, input int a0, input int a1,
                              input int d0, input int b0, input int d1, input int b1,
                              input int nd0, input int nb0, input int nd1, input int nb1);
    vec_t v;
    v.we = 1'(we);   v.wa = IW'(wa);   v.wd = DW'(wd);
    v.re = 1'(re);   v.rsa = IW'(rsa);
    v.a0 = IW'(a0);  v.a1 = IW'(a1);
    v.d0 = DW'(d0);  v.b0 = 1'(b0);   v.d1 = DW'(d1);  v.b1 = 1'(b1);
    v.nd0 = DW'(nd0); v.nb0 = 1'(nb0); v.nd1 = DW'(nd1); v.nb1 = 1'(nb1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    writeEn = 1'b0; writeAddr = '0; writeData = '0;
    reserveEn = 1'b0; reserveAddr = '0; clearReq = 1'b0;
  endtask

  task automatic do_write(input int a, input int d);
    @(negedge clk);
    idle_inputs();
    writeEn = 1'b1; writeAddr = IW'(a); writeData = DW'(d);
  endtask

  function automatic logic [DW-1:0] fill_val(input int j);
    return DW'(16'h1111 * j);
  endfunction

  initial begin
    idle_inputs();
    readAddr = '0;
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    // reset state seen through both ports at every index
    for (int a = 0; a < NR; a++) begin
      readAddr[0] = IW'(a);
      readAddr[1] = IW'(NR - 1 - a);
      #1;
      chk($sformatf("rst_d0_r%0d", a), 32'(readData[0]), 32'h0);
      chk($sformatf("rst_d1_r%0d", a), 32'(readData[1]), 32'h0);
      chk($sformatf("rst_busy_r%0d", a), 32'(readBusy), 32'h0);
    end
    chk("rst_ready", 32'(ready), 32'h1);
    @(negedge clk);
    rstN = 1'b1;

    //            we wa wd      re rsa a0 a1  d0      b0 d1      b1 nd0     nb0 nd1     nb1
    vt[0]  = mk(0, 0, 0,       0, 0,  0, 3,  0,      0, 0,      0, 0,      0,  0,      0);
    vt[1]  = mk(1, 3, 'hBEEF,  0, 0,  3, 1,  'hBEEF, 0, 0,      0, 0,      0,  0,      0);
    vt[2]  = mk(0, 0, 0,       0, 0,  3, 5,  'hBEEF, 0, 0,      0, 'hBEEF, 0,  0,      0);
    vt[3]  = mk(1, 5, 'h1234,  0, 0,  3, 5,  'hBEEF, 0, 'h1234, 0, 'hBEEF, 0,  0,      0);
    vt[4]  = mk(0, 0, 0,       1, 2,  2, 5,  0,      0, 'h1234, 0, 0,      0,  'h1234, 0);
    vt[5]  = mk(0, 0, 0,       0, 0,  2, 3,  0,      1, 'hBEEF, 0, 0,      1,  'hBEEF, 0);
    vt[6]  = mk(1, 2, 7,       0, 0,  2, 2,  7,      0, 7,      0, 0,      1,  0,      1);
    vt[7]  = mk(0, 0, 0,       0, 0,  2, 2,  7,      0, 7,      0, 7,      0,  7,      0);
    vt[8]  = mk(1, 4, 9,       1, 4,  4, 4,  9,      0, 9,      0, 0,      0,  0,      0);
    vt[9]  = mk(0, 0, 0,       0, 0,  4, 4,  9,      1, 9,      1, 9,      1,  9,      1);
    vt[10] = mk(1, 4, 'hA,     1, 4,  4, 4,  'hA,    1, 'hA,    1, 9,      1,  9,      1);
    vt[11] = mk(1, 4, 'hB,     0, 0,  4, 6,  'hB,    0, 0,      0, 'hA,    1,  0,      0);
    vt[12] = mk(1, 0, 'hFFFF,  1, 0,  0, 0,  0,      0, 0,      0, 0,      0,  0,      0);
    vt[13] = mk(0, 0, 0,       0, 0,  0, 4,  0,      0, 'hB,    0, 0,      0,  'hB,    0);
    vt[14] = mk(1, 7, 'h77,    1, 6,  6, 7,  0,      0, 'h77,   0, 0,      0,  0,      0);
    vt[15] = mk(0, 0, 0,       0, 0,  6, 7,  0,      1, 'h77,   0, 0,      1,  'h77,   0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      writeEn = vt[i].we; writeAddr = vt[i].wa; writeData = vt[i].wd;
      reserveEn = vt[i].re; reserveAddr = vt[i].rsa; clearReq = 1'b0;
      readAddr[0] = vt[i].a0; readAddr[1] = vt[i].a1;
      #2;
      chk($sformatf("v%0d_d0", i),  32'(readData[0]),    32'(vt[i].d0));
      chk($sformatf("v%0d_b0", i),  32'(readBusy[0]),    32'(vt[i].b0));
      chk($sformatf("v%0d_d1", i),  32'(readData[1]),    32'(vt[i].d1));
      chk($sformatf("v%0d_b1", i),  32'(readBusy[1]),    32'(vt[i].b1));
      chk($sformatf("v%0d_nd0", i), 32'(nb_readData[0]), 32'(vt[i].nd0));
      chk($sformatf("v%0d_nb0", i), 32'(nb_readBusy[0]), 32'(vt[i].nb0));
      chk($sformatf("v%0d_nd1", i), 32'(nb_readData[1]), 32'(vt[i].nd1));
      chk($sformatf("v%0d_nb1", i), 32'(nb_readBusy[1]), 32'(vt[i].nb1));
      chk($sformatf("v%0d_rdy", i), 32'({ready, nb_ready}), 32'h3);
    end

    // fill r1..r7, reserve r3 on the last fill cycle
    for (int j = 1; j < NR; j++) do_write(j, fill_val(j));
    reserveEn = 1'b1; reserveAddr = 3'd3;
    @(negedge clk);
    idle_inputs();
    readAddr[0] = 3'd3; readAddr[1] = 3'd6;
    #2;
    chk("fill_r3_busy", 32'(readBusy[0]), 32'h1);
    chk("fill_r6", 32'(readData[1]), 32'(fill_val(6)));

    // clear request with a write alongside: write accepted, ready still 1
    @(negedge clk);
    clearReq = 1'b1; writeEn = 1'b1; writeAddr = 3'd1; writeData = 16'h5555;
    #2;
    chk("clr_c0_ready", 32'(ready), 32'h1);

    // eight cycles with ready low; writes/reserves/clearReq dropped, reads live
    for (int k = 1; k <= NR; k++) begin
      @(negedge clk);
      idle_inputs();
      writeEn = 1'b1; writeAddr = 3'd2; writeData = 16'hABCD;
      reserveEn = 1'b1; reserveAddr = 3'd5;
      clearReq = (k == 3);
      readAddr[0] = 3'd2;
      readAddr[1] = (k == 1) ? 3'd1 : 3'd5;
      #2;
      chk($sformatf("clr_c%0d_ready", k), 32'(ready), 32'h0);
      chk($sformatf("clr_c%0d_d0", k), 32'(readData[0]),
          (2 < k - 1) ? 32'h0 : 32'(fill_val(2)));
      chk($sformatf("clr_c%0d_d1", k), 32'(readData[1]),
          (k == 1) ? 32'h5555 : ((5 < k - 1) ? 32'h0 : 32'(fill_val(5))));
      chk($sformatf("clr_c%0d_busy", k), 32'(readBusy), 32'h0);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    chk("clr_exit_ready", 32'(ready), 32'h1);
    for (int a = 0; a < NR; a++) begin
      readAddr[0] = IW'(a);
      #1;
      chk($sformatf("clr_done_r%0d", a), 32'({readBusy[0], readData[0]}), 32'h0);
    end

    // reset asserted in the middle of a clear
    do_write(6, 16'h6666);
    @(negedge clk);
    idle_inputs();
    clearReq = 1'b1;
    readAddr[0] = 3'd6;
    #2;
    chk("rst_mid_pre_d", 32'(readData[0]), 32'h6666);
    @(negedge clk);
    clearReq = 1'b0;
    #2;
    chk("rst_mid_in_clear", 32'(ready), 32'h0);
    @(negedge clk);
    #3;
    rstN = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(ready), 32'h1);
    chk("rst_mid_d6", 32'(readData[0]), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_mid_stays_idle", 32'(ready), 32'h1);
    do_write(6, 16'h0606);
    @(negedge clk);
    idle_inputs();
    #2;
    chk("post_rst_write", 32'(readData[0]), 32'h0606);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
